vga_capture: RTL

//   Sink end of the VGA link: samples hsync/vsync/r/g/b as driven by the VGA controller in the

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_sync_edge.sv | 39 +++
 rtl/vga_capture.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, counter limits and the capture lock-FSM encoding.
// Used by vga_sync_edge and vga_capture.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int PIX_DIV_DEF  = 2;

    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        WAIT_V = 2'd1,
        LOCKED = 2'd2
    } cap_state_t;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input, normalises its polarity, flags the inactive->active edge
// and counts clocks since the previous edge (saturating).
module vga_sync_edge import vga_timing_pkg::*; #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    output logic             pulse,
    output logic [CNT_W-1:0] period,
    output logic             saturated
);

    logic sync_r;
    logic act;
    logic act_d;

    assign act       = (sync_r == SYNC_POL);
    assign pulse     = act & ~act_d;
    assign saturated = (period == CNT_MAX) & ~pulse;

    // period holds the clock count since the last edge; it reads as the line length on an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= ~SYNC_POL;
            act_d  <= 1'b0;
            period <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            sync_r <= sync;
            act_d  <= act;
            if (pulse)
                period <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (period != CNT_MAX)
                period <= period + 1'b1;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// VGA sink: locks to hsync/vsync timing, recovers pixel coordinates and strobes active pixels.
// Optional per-frame pixel checksum on frame_sum when VGA_CAP_SUM_EN is defined.
module vga_capture import vga_timing_pkg::*; #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIX_DIV  = PIX_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] r,
    input  logic [2:0] g,
    input  logic [1:0] b,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       err_hsync,
    output logic       err_vsync
`ifdef VGA_CAP_SUM_EN
    ,
    output logic [15:0] frame_sum
`endif
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int PH_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] LINE_CLKS = CNT_W'(H_TOTAL * PIX_DIV);
    localparam logic [CNT_W-1:0] FRAME_LNS = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_START   = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_END     = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_START   = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_END     = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    logic             hs_edge;
    logic [CNT_W-1:0] hs_period;
    logic             hs_sat;
    logic             vs_edge;
    logic [CNT_W-1:0] vs_period_unused;
    logic             vs_sat_unused;

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hsync_edge (
        .clk       (clk),
        .rst       (rst),
        .sync      (hsync),
        .pulse     (hs_edge),
        .period    (hs_period),
        .saturated (hs_sat)
    );

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vsync_edge (
        .clk       (clk),
        .rst       (rst),
        .sync      (vsync),
        .pulse     (vs_edge),
        .period    (vs_period_unused),
        .saturated (vs_sat_unused)
    );

    cap_state_t       state;
    logic             match_one;
    logic [7:0]       rgb_q;
    logic [PH_W-1:0]  ph_q, ph_c;
    logic [CNT_W-1:0] h_q, h_c;
    logic [CNT_W-1:0] v_q, v_c;
    logic             sample;
    logic             h_act, v_act;
    logic             pix_hit;
    logic             line_ok;
    logic             h_bad, v_bad;

    // Current-cycle pixel phase, column and line, with the sync edges folded in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ph_c = ph_q;
        h_c  = h_q;
        v_c  = v_q;
        if (hs_edge) begin
            ph_c = '0;
            h_c  = '0;
        end
        if (vs_edge)
            v_c = '0;
        else if (hs_edge && (v_q != CNT_MAX))
            v_c = v_q + 1'b1;
    end

    assign sample  = (ph_c == PH_LAST);
    assign h_act   = (h_c >= H_START) && (h_c < H_END);
    assign v_act   = (v_c >= V_START) && (v_c < V_END);
    assign pix_hit = (state == LOCKED) && sample && h_act && v_act;
    assign line_ok = (hs_period == LINE_CLKS);
    assign h_bad   = (hs_edge && !line_ok) || hs_sat;
    assign v_bad   = vs_edge && ((v_q + 1'b1) != FRAME_LNS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            match_one <= 1'b0;
            locked    <= 1'b0;
            err_hsync <= 1'b0;
            err_vsync <= 1'b0;
        end else begin
            err_hsync <= 1'b0;
            err_vsync <= 1'b0;
            unique case (state)
                SEARCH: begin
                    if (hs_edge) begin
                        if (!line_ok) begin
                            match_one <= 1'b0;
                        end else if (match_one) begin
                            match_one <= 1'b0;
                            state     <= WAIT_V;
                        end else begin
                            match_one <= 1'b1;
                        end
                    end
                end
                WAIT_V: begin
                    if (h_bad) begin
                        state <= SEARCH;
                    end else if (vs_edge) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    err_hsync <= h_bad;
                    err_vsync <= v_bad;
                    if (h_bad || v_bad) begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        match_one <= 1'b0;
                    end
                end
                default: begin
                    state     <= SEARCH;
                    locked    <= 1'b0;
                    match_one <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q       <= '0;
            ph_q        <= '0;
            h_q         <= '0;
            v_q         <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rgb_q <= {r, g, b};
            v_q   <= v_c;
            if (sample) begin
                ph_q <= '0;
                h_q  <= h_c + 1'b1;
            end else begin
                ph_q <= ph_c + 1'b1;
                h_q  <= h_c;
            end
            pix_valid   <= pix_hit;
            frame_start <= pix_hit && (h_c == H_START) && (v_c == V_START);
            if (pix_hit) begin
                pix_x    <= 10'(h_c - H_START);
                pix_y    <= 10'(v_c - V_START);
                pix_data <= rgb_q;
            end
        end
    end

`ifdef VGA_CAP_SUM_EN
    logic [15:0] sum_acc;

    // A pixel landing on the closing vsync edge still belongs to the frame being closed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else if (vs_edge) begin
            frame_sum <= sum_acc + (pix_valid ? {8'h00, pix_data} : 16'h0000);
            sum_acc   <= '0;
        end else if (pix_valid) begin
            sum_acc <= sum_acc + {8'h00, pix_data};
        end
    end
`endif

endmodule
